loopback_pattern_checker: RTL



---
 rtl/loopback_pattern_checker.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/loopback_pattern_checker.sv
// Loopback pattern generator (counter / PRBS7) and self-synchronising checker.
// Optional LOOPBACK_ERR_INJ_EN adds inject_err for single-word bit-0 corruption.
module loopback_pattern_checker #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned MISS_CNT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             gen_en,
    input  logic             clr,
`ifdef LOOPBACK_ERR_INJ_EN
    input  logic             inject_err,
`endif
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_valid,
    output logic             locked,
    output logic             lock_lost,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W  = $clog2(MISS_CNT + 1);
    localparam logic [6:0]  LFSR_INIT = 7'h7F;

    typedef enum logic {SEEK, LOCKED} chk_state_t;

    // First generated bit ends up in the MSB; the last seven bits are the new LFSR state.
    function automatic logic [WIDTH-1:0] prbs_word(input logic [6:0] seed);
        logic [6:0]       s;
        logic [WIDTH-1:0] w;
        logic             nb;
        s = seed;
        w = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            nb = s[6] ^ s[5];
            s  = {s[5:0], nb};
            w  = {w[WIDTH-2:0], nb};
        end
        return w;
    endfunction

    function automatic logic [WIDTH-1:0] next_word(input logic m, input logic [WIDTH-1:0] w);
        return m ? prbs_word(w[6:0]) : w + WIDTH'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    logic             mode_q;
    logic             mode_change;
    logic [WIDTH-1:0] gen_cnt;
    logic [6:0]       gen_lfsr;
    logic [WIDTH-1:0] gen_prbs;
    logic [WIDTH-1:0] gen_word;
    logic [WIDTH-1:0] inj_mask;

    chk_state_t       state;
    logic             seeded;
    logic [WIDTH-1:0] exp_word;
    logic [WIDTH-1:0] exp_next;
    logic [WIDTH-1:0] seed_next;
    logic             seed_ok;
    logic             rx_match;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;

    always_comb begin
        inj_mask = '0;
`ifdef LOOPBACK_ERR_INJ_EN
        inj_mask[0] = inject_err;
`endif
        mode_change = (mode != mode_q);
        gen_prbs    = prbs_word(gen_lfsr);
        gen_word    = mode ? gen_prbs : gen_cnt;
        exp_next    = next_word(mode, exp_word);
        seed_next   = next_word(mode, rx_data);
        seed_ok     = !(mode && (rx_data[6:0] == 7'd0));
        rx_match    = (rx_data == exp_word);
    end

    // A mode change spends its edge restarting the pattern; no word is emitted on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
            gen_cnt  <= '0;
            gen_lfsr <= LFSR_INIT;
            mode_q   <= 1'b0;
        end else begin
            mode_q <= mode;
            if (mode_change) begin
                gen_cnt  <= '0;
                gen_lfsr <= LFSR_INIT;
                tx_valid <= 1'b0;
            end else if (gen_en) begin
                tx_valid <= 1'b1;
                tx_data  <= gen_word ^ inj_mask;
                if (mode) begin
                    gen_lfsr <= gen_prbs[6:0];
                end else begin
                    gen_cnt <= gen_cnt + WIDTH'(1);
                end
            end else begin
                tx_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEEK;
            seeded    <= 1'b0;
            exp_word  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
            err_cnt   <= '0;
            word_cnt  <= '0;
        end else begin
            if (mode_change) begin
                state     <= SEEK;
                locked    <= 1'b0;
                seeded    <= 1'b0;
                match_cnt <= '0;
                miss_cnt  <= '0;
            end else if (rx_valid) begin
                case (state)
                    SEEK: begin
                        if (seeded && rx_match) begin
                            exp_word <= exp_next;
                            if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                match_cnt <= match_cnt + MATCH_W'(1);
                            end
                        end else begin
                            exp_word  <= seed_next;
                            seeded    <= seed_ok;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Prediction free-runs from exp_word so errors never resynchronise it.
                        exp_word <= exp_next;
                        word_cnt <= sat_inc(word_cnt);
                        if (!rx_match) begin
                            err_cnt <= sat_inc(err_cnt);
                            if (miss_cnt == MISS_W'(MISS_CNT - 1)) begin
                                state     <= SEEK;
                                locked    <= 1'b0;
                                lock_lost <= 1'b1;
                                seeded    <= 1'b0;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + MISS_W'(1);
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: state <= SEEK;
                endcase
            end
            if (clr) begin
                err_cnt   <= '0;
                word_cnt  <= '0;
                lock_lost <= 1'b0;
            end
        end
    end

endmodule
